lag_stimulus: RTL

- Transmit-side counterpart of the lag measurement block. It schedules the flash stimulus on the HDMI output, frame-aligned to vsync.
- On a flash frame it pulses measure_start, which drives the measurement block's counter reset (that block's reset_counter). It holds armed high until the photo-sensor edge arrives or a timeout expires. It then blanks for a fixed number of frames and repeats.
- Sits between the video timing generator (frame_start), the sensor edge detector (sensor_trigger), the pattern mixer (flash_on) and the measurement block.

---
 rtl/lag_stimulus_pkg.sv | 22 ++
 rtl/lag_stimulus_if.sv | 27 ++
 rtl/lag_stimulus_frame_tick_counter.sv | 27 ++
 rtl/lag_stimulus.sv | 132 +++++++++++++
 4 files changed

// File: rtl/lag_stimulus_pkg.sv
// Shared definitions for the lag stimulus scheduler: state encoding, default
// frame counts and the frame-counter limit helper.
package lag_stimulus_pkg;

    typedef enum logic [1:0] {
        LS_DARK  = 2'd0,
        LS_FLASH = 2'd1,
        LS_HOLD  = 2'd2
    } ls_state_e;

    localparam int LS_BLANK_FRAMES_DEF   = 8;
    localparam int LS_TIMEOUT_FRAMES_DEF = 60;
    localparam int LS_AVERAGE_BITS       = 4;
    localparam int LS_CNT_W              = 8;

    // The counter fires on the frame_start that would make the count reach n,
    // so the compare value is n-1.
    function automatic logic [LS_CNT_W-1:0] ls_limit(input int unsigned n);
        return LS_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/lag_stimulus_if.sv
// Bundle between the timing/sensor/mixer side (master) and the stimulus
// scheduler (slave).
interface lag_stimulus_if
    import lag_stimulus_pkg::*;
#(
    parameter int SAMPLE_BITS = LS_AVERAGE_BITS
);
    logic                   frame_start;
    logic                   sensor_trigger;
    logic                   config_changed;
    logic                   flash_on;
    logic                   measure_start;
    logic                   armed;
    logic                   sample_done;
    logic                   timeout;
    logic [SAMPLE_BITS-1:0] sample_index;

    modport master (
        output frame_start, sensor_trigger, config_changed,
        input  flash_on, measure_start, armed, sample_done, timeout, sample_index
    );

    modport slave (
        input  frame_start, sensor_trigger, config_changed,
        output flash_on, measure_start, armed, sample_done, timeout, sample_index
    );
endinterface

// File: rtl/lag_stimulus_frame_tick_counter.sv
// Saturating 8-bit frame counter with synchronous clear and a compare-to-limit
// flag; DARK and FLASH share it with different limits.
module lag_stimulus_frame_tick_counter
    import lag_stimulus_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_clear,
    input  logic                i_inc,
    input  logic [LS_CNT_W-1:0] i_limit,
    output logic                o_done
);
    logic [LS_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {LS_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/lag_stimulus.sv
// Flash stimulus scheduler: dark gap, flash until sensor edge or timeout,
// hold the flash to the next frame boundary, repeat.
module lag_stimulus
    import lag_stimulus_pkg::*;
#(
    parameter int BLANK_FRAMES   = LS_BLANK_FRAMES_DEF,
    parameter int TIMEOUT_FRAMES = LS_TIMEOUT_FRAMES_DEF,
    parameter int SAMPLE_BITS    = LS_AVERAGE_BITS
)(
    input  logic           clock,
    input  logic           reset_n,
    lag_stimulus_if.slave  bus
);
    localparam logic [LS_CNT_W-1:0] BLANK_LIMIT   = ls_limit(BLANK_FRAMES);
    localparam logic [LS_CNT_W-1:0] TIMEOUT_LIMIT = ls_limit(TIMEOUT_FRAMES);

    ls_state_e              r_state;
    logic                   r_flash_on;
    logic                   r_measure_start;
    logic                   r_armed;
    logic                   r_sample_done;
    logic                   r_timeout;
    logic [SAMPLE_BITS-1:0] r_sample_index;

    logic                   w_cnt_clear;
    logic                   w_cnt_inc;
    logic [LS_CNT_W-1:0]    w_cnt_limit;
    logic                   w_cnt_done;
    logic                   w_fs;
    logic                   w_st;

    assign w_fs = bus.frame_start;
    assign w_st = bus.sensor_trigger;

    // Counter control mirrors the FSM priorities so the count is always clear
    // on entry to DARK and FLASH; a frame_start alongside config_changed is dropped.
    always_comb begin
        w_cnt_limit = (r_state == LS_FLASH) ? TIMEOUT_LIMIT : BLANK_LIMIT;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        if (bus.config_changed) begin
            w_cnt_clear = 1'b1;
        end else begin
            case (r_state)
                LS_DARK: begin
                    w_cnt_clear = w_fs && w_cnt_done;
                    w_cnt_inc   = w_fs;
                end
                LS_FLASH: begin
                    w_cnt_clear = w_st || (w_fs && w_cnt_done);
                    w_cnt_inc   = w_fs;
                end
                default: w_cnt_clear = 1'b1;
            endcase
        end
    end

    lag_stimulus_frame_tick_counter u_frame_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .i_limit (w_cnt_limit),
        .o_done  (w_cnt_done)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= LS_DARK;
            r_flash_on      <= 1'b0;
            r_measure_start <= 1'b0;
            r_armed         <= 1'b0;
            r_sample_done   <= 1'b0;
            r_timeout       <= 1'b0;
            r_sample_index  <= '0;
        end else begin
            r_measure_start <= 1'b0;
            r_sample_done   <= 1'b0;
            r_timeout       <= 1'b0;
            if (bus.config_changed) begin
                r_state        <= LS_DARK;
                r_flash_on     <= 1'b0;
                r_armed        <= 1'b0;
                r_sample_index <= '0;
            end else begin
                case (r_state)
                    LS_DARK: begin
                        if (w_fs && w_cnt_done) begin
                            r_state         <= LS_FLASH;
                            r_flash_on      <= 1'b1;
                            r_armed         <= 1'b1;
                            r_measure_start <= 1'b1;
                        end
                    end
                    LS_FLASH: begin
                        // A sensor edge in the same cycle as the last frame_start still counts.
                        if (w_st) begin
                            r_state        <= LS_HOLD;
                            r_armed        <= 1'b0;
                            r_sample_done  <= 1'b1;
                            r_sample_index <= r_sample_index + 1'b1;
                        end else if (w_fs && w_cnt_done) begin
                            r_state    <= LS_DARK;
                            r_flash_on <= 1'b0;
                            r_armed    <= 1'b0;
                            r_timeout  <= 1'b1;
                        end
                    end
                    LS_HOLD: begin
                        if (w_fs) begin
                            r_state    <= LS_DARK;
                            r_flash_on <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= LS_DARK;
                        r_flash_on <= 1'b0;
                        r_armed    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.flash_on      = r_flash_on;
    assign bus.measure_start = r_measure_start;
    assign bus.armed         = r_armed;
    assign bus.sample_done   = r_sample_done;
    assign bus.timeout       = r_timeout;
    assign bus.sample_index  = r_sample_index;

endmodule
